iterative_execute_unit: RTL and testbench

Parametrised successor to the single-cycle integer execute stage. It sits between operand fetch and writeback and executes the same x86 integer opcode set: MOV, OR, ADD, ADC, SBB, AND, SUB, XOR, CMP, INC, DEC, NEG, NOT, MUL, IMUL and RET-class kill. New relative to the previous stage: a configurable datapath width, a registered RFLAGS subset (CF/ZF/SF/OF) that ADC/SBB really consume, an iterative shift-add multiplier, and valid/ready handshakes on both sides.

---
 rtl/iterative_execute_unit.sv | 338 +++++++++++++++++++++++++++++++++
 tb/tb_iterative_execute_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/iterative_execute_unit.sv
// Integer execute stage: x86 ALU ops in one cycle, MUL/IMUL via an iterative shift-add multiplier.
// Latency: 1 cycle for non-multiply ops, DATA_WIDTH/MUL_BITS_PER_CYCLE + 1 cycles for multiplies.
// Backpressure: inReady drops while multiplying, after RET, or while a result sits unconsumed.
module iterative_execute_unit #(
    parameter int DATA_WIDTH         = 64,
    parameter int MUL_BITS_PER_CYCLE = 1
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  inValid,
    output logic                  inReady,
    input  logic [7:0]            opcodeIn,
    input  logic [1:0]            opcodeLengthIn,
    input  logic                  hasExtendedOpcodeIn,
    input  logic [2:0]            extendedOpcodeIn,
    input  logic [DATA_WIDTH-1:0] operand1In,
    input  logic [DATA_WIDTH-1:0] operand2In,
    input  logic [DATA_WIDTH-1:0] immIn,
    input  logic [3:0]            destRegIn,
    input  logic [3:0]            destRegSpecialIn,
    output logic                  outValid,
    input  logic                  outReady,
    output logic [DATA_WIDTH-1:0] resultOut,
    output logic [DATA_WIDTH-1:0] resultSpecialOut,
    output logic [3:0]            destRegOut,
    output logic [3:0]            destRegSpecialOut,
    output logic                  writeEnableOut,
    output logic                  writeSpecialOut,
    output logic                  successOut,
    output logic [3:0]            flagsOut,
    output logic                  killOut
);

    localparam int W          = DATA_WIDTH;
    localparam int ITERATIONS = DATA_WIDTH / MUL_BITS_PER_CYCLE;
    localparam int CNT_W      = $clog2(ITERATIONS + 1);

    typedef enum logic {IDLE, MUL} stateE;

    typedef enum logic [4:0] {
        OP_BAD, OP_MOV, OP_ADD, OP_OR, OP_ADC, OP_SBB, OP_AND, OP_SUB, OP_XOR, OP_CMP,
        OP_INC, OP_DEC, OP_NEG, OP_NOT, OP_MUL, OP_IMULW, OP_IMULT, OP_RET
    } opKindE;

    typedef struct packed {
        logic [W-1:0] result;
        logic [W-1:0] resultSpecial;
        logic         writeEnable;
        logic         writeSpecial;
        logic         success;
    } commitT;

    function automatic opKindE aluOp(input logic [2:0] idx);
        case (idx)
            3'd0:    return OP_ADD;
            3'd1:    return OP_OR;
            3'd2:    return OP_ADC;
            3'd3:    return OP_SBB;
            3'd4:    return OP_AND;
            3'd5:    return OP_SUB;
            3'd6:    return OP_XOR;
            default: return OP_CMP;
        endcase
    endfunction

    stateE          state;
    commitT         outReg;
    logic [CNT_W-1:0] counter;
    logic [2*W-1:0] mcand;
    logic [W-1:0]   mplr;
    logic [2*W-1:0] acc;
    logic           negate;
    opKindE         mulKind;
    logic [3:0]     pendDest;
    logic [3:0]     pendDestSpecial;

    // ---------------- decode ----------------
    opKindE       decOp;
    logic [W-1:0] decB;
    logic [W-1:0] decMulA;
    logic [W-1:0] decMulB;

    always_comb begin
        decOp   = OP_BAD;
        decB    = operand2In;
        decMulA = operand1In;
        decMulB = operand2In;
        if (opcodeLengthIn == 2'd2) begin
            if (opcodeIn == 8'hAF) decOp = OP_IMULT;
        end else if (opcodeLengthIn == 2'd1) begin
            if (opcodeIn[7:6] == 2'b00 && (opcodeIn[2:0] == 3'b001 || opcodeIn[2:0] == 3'b011)) begin
                decOp = aluOp(opcodeIn[5:3]);
            end else if (opcodeIn[7:6] == 2'b00 && opcodeIn[2:0] == 3'b101) begin
                decOp = aluOp(opcodeIn[5:3]);
                decB  = immIn;
            end else begin
                case (opcodeIn)
                    8'h81, 8'h83: begin
                        if (hasExtendedOpcodeIn) decOp = aluOp(extendedOpcodeIn);
                        decB = immIn;
                    end
                    8'hC7: begin
                        if (hasExtendedOpcodeIn && extendedOpcodeIn == 3'd0) decOp = OP_MOV;
                        decB = immIn;
                    end
                    8'h89, 8'h8B: decOp = OP_MOV;
                    8'hF7: begin
                        if (hasExtendedOpcodeIn) begin
                            case (extendedOpcodeIn)
                                3'd2:    decOp = OP_NOT;
                                3'd3:    decOp = OP_NEG;
                                3'd4:    decOp = OP_MUL;
                                3'd5:    decOp = OP_IMULW;
                                default: decOp = OP_BAD;
                            endcase
                        end
                    end
                    8'hFF: begin
                        if (hasExtendedOpcodeIn && extendedOpcodeIn == 3'd0) decOp = OP_INC;
                        if (hasExtendedOpcodeIn && extendedOpcodeIn == 3'd1) decOp = OP_DEC;
                    end
                    8'h69, 8'h6B: begin
                        decOp   = OP_IMULT;
                        decMulA = operand2In;
                        decMulB = immIn;
                    end
                    8'hC3, 8'hCB, 8'hCF: decOp = OP_RET;
                    default: begin
                        if (opcodeIn[7:3] == 5'b10111) begin
                            decOp = OP_MOV;
                            decB  = immIn;
                        end
                    end
                endcase
            end
        end
    end

    logic isMul;
    logic signedMul;
    assign isMul     = (decOp == OP_MUL) || (decOp == OP_IMULW) || (decOp == OP_IMULT);
    assign signedMul = (decOp != OP_MUL);

    logic accept;
    assign inReady = (state == IDLE) && !killOut && (!outValid || outReady);
    assign accept  = inValid && inReady;

    // ---------------- single-cycle ALU ----------------
    logic         cin;
    logic [W-1:0] addB;
    logic [W-1:0] subA;
    logic [W-1:0] subB;
    logic [W:0]   addWide;
    logic [W:0]   subWide;
    logic         addOf;
    logic         subOf;

    always_comb begin
        cin  = (decOp == OP_ADC || decOp == OP_SBB) ? flagsOut[3] : 1'b0;
        addB = (decOp == OP_INC) ? {{(W-1){1'b0}}, 1'b1} : decB;
        subA = (decOp == OP_NEG) ? {W{1'b0}} : operand1In;
        subB = (decOp == OP_NEG) ? operand1In
             : (decOp == OP_DEC) ? {{(W-1){1'b0}}, 1'b1} : decB;
        addWide = {1'b0, operand1In} + {1'b0, addB} + {{W{1'b0}}, cin};
        // Top bit of the widened difference is the borrow.
        subWide = {1'b0, subA} - {1'b0, subB} - {{W{1'b0}}, cin};
        addOf = (operand1In[W-1] == addB[W-1]) && (addWide[W-1] != operand1In[W-1]);
        subOf = (subA[W-1] != subB[W-1]) && (subWide[W-1] != subA[W-1]);
    end

    commitT       aluCommit;
    logic [3:0]   aluFlags;
    logic [W-1:0] aluRes;
    logic         aluCf;
    logic         aluOf;
    logic         setFlags;

    always_comb begin
        aluCommit             = '0;
        aluCommit.success     = 1'b1;
        aluCommit.writeEnable = 1'b1;
        aluRes   = '0;
        aluCf    = flagsOut[3];
        aluOf    = 1'b0;
        setFlags = 1'b0;
        case (decOp)
            OP_MOV: aluRes = decB;
            OP_ADD, OP_ADC, OP_INC: begin
                aluRes   = addWide[W-1:0];
                aluCf    = (decOp == OP_INC) ? flagsOut[3] : addWide[W];
                aluOf    = addOf;
                setFlags = 1'b1;
            end
            OP_SUB, OP_SBB, OP_CMP, OP_DEC: begin
                aluRes   = subWide[W-1:0];
                aluCf    = (decOp == OP_DEC) ? flagsOut[3] : subWide[W];
                aluOf    = subOf;
                setFlags = 1'b1;
            end
            OP_NEG: begin
                aluRes   = subWide[W-1:0];
                aluCf    = |operand1In;
                aluOf    = subOf;
                setFlags = 1'b1;
            end
            OP_OR: begin
                aluRes   = operand1In | decB;
                aluCf    = 1'b0;
                setFlags = 1'b1;
            end
            OP_AND: begin
                aluRes   = operand1In & decB;
                aluCf    = 1'b0;
                setFlags = 1'b1;
            end
            OP_XOR: begin
                aluRes   = operand1In ^ decB;
                aluCf    = 1'b0;
                setFlags = 1'b1;
            end
            OP_NOT: aluRes = ~operand1In;
            OP_RET: aluCommit.writeEnable = 1'b0;
            default: begin
                aluCommit.success     = 1'b0;
                aluCommit.writeEnable = 1'b0;
            end
        endcase
        if (decOp == OP_CMP) aluCommit.writeEnable = 1'b0;
        aluCommit.result = aluRes;
        aluFlags = setFlags ? {aluCf, aluRes == '0, aluRes[W-1], aluOf} : flagsOut;
    end

    // ---------------- multiplier ----------------
    logic [W-1:0] magA;
    logic [W-1:0] magB;
    assign magA = (signedMul && decMulA[W-1]) ? {W{1'b0}} - decMulA : decMulA;
    assign magB = (signedMul && decMulB[W-1]) ? {W{1'b0}} - decMulB : decMulB;

    logic [2*W-1:0] partial;
    logic [2*W-1:0] accNext;
    logic [2*W-1:0] product;
    logic [W-1:0]   prodLow;
    logic [W-1:0]   prodHigh;
    logic           mulOv;
    commitT         mulCommit;
    logic [3:0]     mulFlags;

    always_comb begin
        partial = '0;
        for (int j = 0; j < MUL_BITS_PER_CYCLE; j++) begin
            if (mplr[j]) partial = partial + (mcand << j);
        end
        accNext  = acc + partial;
        product  = negate ? {(2*W){1'b0}} - accNext : accNext;
        prodLow  = product[W-1:0];
        prodHigh = product[2*W-1:W];
        mulOv    = (mulKind == OP_MUL) ? (prodHigh != '0) : (prodHigh != {W{prodLow[W-1]}});
        mulCommit               = '0;
        mulCommit.result        = prodLow;
        mulCommit.writeEnable   = 1'b1;
        mulCommit.success       = 1'b1;
        if (mulKind != OP_IMULT) begin
            mulCommit.resultSpecial = prodHigh;
            mulCommit.writeSpecial  = 1'b1;
        end
        mulFlags = {mulOv, prodLow == '0, prodLow[W-1], mulOv};
    end

    // ---------------- state and output register ----------------
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state             <= IDLE;
            outReg            <= '0;
            outValid          <= 1'b0;
            destRegOut        <= '0;
            destRegSpecialOut <= '0;
            flagsOut          <= '0;
            killOut           <= 1'b0;
            counter           <= '0;
            mcand             <= '0;
            mplr              <= '0;
            acc               <= '0;
            negate            <= 1'b0;
            mulKind           <= OP_BAD;
            pendDest          <= '0;
            pendDestSpecial   <= '0;
        end else begin
            if (outValid && outReady) outValid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (isMul) begin
                            state           <= MUL;
                            counter         <= CNT_W'(ITERATIONS);
                            mcand           <= {{W{1'b0}}, magA};
                            mplr            <= magB;
                            acc             <= '0;
                            negate          <= signedMul && (decMulA[W-1] ^ decMulB[W-1]);
                            mulKind         <= decOp;
                            pendDest        <= destRegIn;
                            pendDestSpecial <= destRegSpecialIn;
                        end else begin
                            outReg            <= aluCommit;
                            outValid          <= 1'b1;
                            flagsOut          <= aluFlags;
                            destRegOut        <= destRegIn;
                            destRegSpecialOut <= destRegSpecialIn;
                            if (decOp == OP_RET) killOut <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    acc     <= accNext;
                    mcand   <= mcand << MUL_BITS_PER_CYCLE;
                    mplr    <= mplr >> MUL_BITS_PER_CYCLE;
                    counter <= counter - 1'b1;
                    // Last iteration commits straight from the combinational sum.
                    if (counter == CNT_W'(1)) begin
                        state             <= IDLE;
                        outReg            <= mulCommit;
                        outValid          <= 1'b1;
                        flagsOut          <= mulFlags;
                        destRegOut        <= pendDest;
                        destRegSpecialOut <= pendDestSpecial;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign resultOut        = outReg.result;
    assign resultSpecialOut = outReg.resultSpecial;
    assign writeEnableOut   = outReg.writeEnable;
    assign writeSpecialOut  = outReg.writeSpecial;
    assign successOut       = outReg.success;

endmodule

// File: tb/tb_iterative_execute_unit.sv
// Directed bench for iterative_execute_unit (64-bit datapath, 1 multiplier bit per cycle).
module tb_iterative_execute_unit;

    logic        clk = 1'b0;
    logic        resetN;
    logic        inValid;
    logic        inReady;
    logic [7:0]  opcodeIn;
    logic [1:0]  opcodeLengthIn;
    logic        hasExtendedOpcodeIn;
    logic [2:0]  extendedOpcodeIn;
    logic [63:0] operand1In;
    logic [63:0] operand2In;
    logic [63:0] immIn;
    logic [3:0]  destRegIn;
    logic [3:0]  destRegSpecialIn;
    logic        outValid;
    logic        outReady;
    logic [63:0] resultOut;
    logic [63:0] resultSpecialOut;
    logic [3:0]  destRegOut;
    logic [3:0]  destRegSpecialOut;
    logic        writeEnableOut;
    logic        writeSpecialOut;
    logic        successOut;
    logic [3:0]  flagsOut;
    logic        killOut;

    int passCount  = 0;
    int checkCount = 0;
    int failCount  = 0;

    iterative_execute_unit #(.DATA_WIDTH(64), .MUL_BITS_PER_CYCLE(1)) dut (
        .clk(clk), .resetN(resetN), .inValid(inValid), .inReady(inReady),
        .opcodeIn(opcodeIn), .opcodeLengthIn(opcodeLengthIn),
        .hasExtendedOpcodeIn(hasExtendedOpcodeIn), .extendedOpcodeIn(extendedOpcodeIn),
        .operand1In(operand1In), .operand2In(operand2In), .immIn(immIn),
        .destRegIn(destRegIn), .destRegSpecialIn(destRegSpecialIn),
        .outValid(outValid), .outReady(outReady),
        .resultOut(resultOut), .resultSpecialOut(resultSpecialOut),
        .destRegOut(destRegOut), .destRegSpecialOut(destRegSpecialOut),
        .writeEnableOut(writeEnableOut), .writeSpecialOut(writeSpecialOut),
        .successOut(successOut), .flagsOut(flagsOut), .killOut(killOut)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] opc, input logic [1:0] len, input logic hasExt,
                         input logic [2:0] ext, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] imm, input logic [3:0] dst, input logic [3:0] dstSpecial);
        opcodeIn            = opc;
        opcodeLengthIn      = len;
        hasExtendedOpcodeIn = hasExt;
        extendedOpcodeIn    = ext;
        operand1In          = a;
        operand2In          = b;
        immIn               = imm;
        destRegIn           = dst;
        destRegSpecialIn    = dstSpecial;
        inValid             = 1'b1;
    endtask

    // Counts cycles from the accept edge until outValid rises (bounded).
    task automatic waitResult(output int cycles, output logic sawReady);
        cycles   = 1;
        sawReady = 1'b0;
        while (!outValid && cycles < 200) begin
            if (inReady) sawReady = 1'b1;
            tick();
            cycles++;
        end
    endtask

    int   cycles;
    logic sawReady;
    logic stable;
    logic sawValid;

    initial begin
        resetN = 1'b0; inValid = 1'b0; outReady = 1'b1;
        opcodeIn = '0; opcodeLengthIn = 2'd1; hasExtendedOpcodeIn = 1'b0; extendedOpcodeIn = '0;
        operand1In = '0; operand2In = '0; immIn = '0; destRegIn = '0; destRegSpecialIn = '0;
        tick(); tick();
        check("reset_outValid", 64'(outValid), 64'd0);
        check("reset_result", resultOut, 64'd0);
        check("reset_resultSpecial", resultSpecialOut, 64'd0);
        check("reset_ctrl", 64'({writeEnableOut, writeSpecialOut, successOut, killOut}), 64'd0);
        check("reset_flags", 64'(flagsOut), 64'd0);
        check("reset_tags", 64'({destRegOut, destRegSpecialOut}), 64'd0);
        resetN = 1'b1;
        tick();
        check("idle_inReady", 64'(inReady), 64'd1);

        // ADD 01: signed overflow into the sign bit
        drive(8'h01, 2'd1, 1'b0, 3'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'd3, 4'd0);
        check("add_not_yet_valid", 64'(outValid), 64'd0);
        tick();
        check("add_valid_next_cycle", 64'(outValid), 64'd1);
        check("add_result", resultOut, 64'h8000_0000_0000_0000);
        check("add_flags", 64'(flagsOut), 64'(4'b0011));
        check("add_ctrl", 64'({writeEnableOut, writeSpecialOut, successOut}), 64'(3'b101));
        check("add_dest", 64'(destRegOut), 64'd3);

        // 83/0 back-to-back: wraps to zero with carry
        drive(8'h83, 2'd1, 1'b1, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd1, 4'd4, 4'd0);
        check("b2b_inReady", 64'(inReady), 64'd1);
        tick();
        check("addimm_result", resultOut, 64'd0);
        check("addimm_flags", 64'(flagsOut), 64'(4'b1100));

        // 11 ADC consumes CF=1: 5 + 3 + 1
        drive(8'h11, 2'd1, 1'b0, 3'd0, 64'd5, 64'd3, 64'd0, 4'd5, 4'd0);
        tick();
        check("adc_result", resultOut, 64'd9);
        check("adc_flags", 64'(flagsOut), 64'd0);

        // F7/4 MUL 2^32 * 2^32
        drive(8'hF7, 2'd1, 1'b1, 3'd4, 64'h1_0000_0000, 64'h1_0000_0000, 64'd0, 4'd0, 4'd2);
        tick();
        inValid = 1'b0;
        waitResult(cycles, sawReady);
        check("mul_latency", 64'(cycles), 64'd65);
        check("mul_inReady_low", 64'(sawReady), 64'd0);
        check("mul_low", resultOut, 64'd0);
        check("mul_high", resultSpecialOut, 64'd1);
        check("mul_cf_of", 64'({flagsOut[3], flagsOut[0]}), 64'(2'b11));
        check("mul_ctrl", 64'({writeEnableOut, writeSpecialOut, successOut}), 64'(3'b111));
        check("mul_tags", 64'({destRegOut, destRegSpecialOut}), 64'(8'h02));

        // F7/5 IMUL -3 * 5
        drive(8'hF7, 2'd1, 1'b1, 3'd5, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 64'd0, 4'd0, 4'd2);
        tick();
        inValid = 1'b0;
        waitResult(cycles, sawReady);
        check("imul_latency", 64'(cycles), 64'd65);
        check("imul_low", resultOut, 64'hFFFF_FFFF_FFFF_FFF1);
        check("imul_high", resultSpecialOut, 64'hFFFF_FFFF_FFFF_FFFF);
        check("imul_cf_of", 64'({flagsOut[3], flagsOut[0]}), 64'd0);

        // 69 IMUL op2 * imm, low half only
        drive(8'h69, 2'd1, 1'b0, 3'd0, 64'd0, 64'd7, 64'd6, 4'd1, 4'd0);
        tick();
        inValid = 1'b0;
        waitResult(cycles, sawReady);
        check("imul3_result", resultOut, 64'd42);
        check("imul3_special", 64'({writeSpecialOut}), 64'd0);

        // Stall: second ADD waits while outReady is low
        tick();
        outReady = 1'b0;
        drive(8'h01, 2'd1, 1'b0, 3'd0, 64'd10, 64'd20, 64'd0, 4'd5, 4'd0);
        tick();
        drive(8'h01, 2'd1, 1'b0, 3'd0, 64'd100, 64'd1, 64'd0, 4'd6, 4'd0);
        stable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (!(outValid && !inReady && resultOut == 64'd30 && destRegOut == 4'd5)) stable = 1'b0;
            tick();
        end
        check("stall_stable", 64'(stable), 64'd1);
        check("stall_hold_result", resultOut, 64'd30);
        outReady = 1'b1;
        #1;
        check("stall_release_inReady", 64'(inReady), 64'd1);
        tick();
        check("stall_second_result", resultOut, 64'd101);
        check("stall_second_dest", 64'(destRegOut), 64'd6);

        // 39 CMP 5 vs 7: borrow and negative, no write
        drive(8'h39, 2'd1, 1'b0, 3'd0, 64'd5, 64'd7, 64'd0, 4'd2, 4'd0);
        tick();
        check("cmp_flags", 64'(flagsOut), 64'(4'b1010));
        check("cmp_ctrl", 64'({writeEnableOut, successOut}), 64'(2'b01));

        // Unsupported 90: flags untouched
        drive(8'h90, 2'd1, 1'b0, 3'd0, 64'd1, 64'd2, 64'd0, 4'd2, 4'd0);
        tick();
        check("bad_ctrl", 64'({writeEnableOut, writeSpecialOut, successOut}), 64'd0);
        check("bad_flags", 64'(flagsOut), 64'(4'b1010));

        // 19 SBB with CF=1: 10 - 3 - 1
        drive(8'h19, 2'd1, 1'b0, 3'd0, 64'd10, 64'd3, 64'd0, 4'd7, 4'd0);
        tick();
        check("sbb_result", resultOut, 64'd6);
        check("sbb_flags", 64'(flagsOut), 64'd0);

        // C3 RET: sticky kill
        drive(8'hC3, 2'd1, 1'b0, 3'd0, 64'd0, 64'd0, 64'd0, 4'd0, 4'd0);
        tick();
        check("ret_kill", 64'(killOut), 64'd1);
        check("ret_ctrl", 64'({writeEnableOut, successOut}), 64'(2'b01));
        drive(8'h01, 2'd1, 1'b0, 3'd0, 64'd1, 64'd1, 64'd0, 4'd1, 4'd0);
        tick(); tick(); tick();
        check("kill_inReady", 64'(inReady), 64'd0);
        check("kill_no_accept", 64'({outValid, killOut}), 64'(2'b01));
        inValid = 1'b0;

        // Reset pulse mid-multiply aborts without commit
        resetN = 1'b0;
        tick();
        resetN = 1'b1;
        drive(8'hF7, 2'd1, 1'b1, 3'd4, 64'd3, 64'd4, 64'd0, 4'd1, 4'd2);
        tick();
        inValid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        resetN = 1'b0;
        tick();
        resetN = 1'b1;
        check("midmul_reset_out", 64'({outValid, writeEnableOut, writeSpecialOut, successOut, killOut}), 64'd0);
        check("midmul_reset_result", resultOut | resultSpecialOut, 64'd0);
        check("midmul_reset_flags", 64'(flagsOut), 64'd0);
        sawValid = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (outValid) sawValid = 1'b1;
            tick();
        end
        check("midmul_no_commit", 64'(sawValid), 64'd0);
        check("midmul_idle_ready", 64'(inReady), 64'd1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
